sprite_pixel_fetcher: RTL and testbench
=======================================

// Module: sprite_pixel_fetcher
// PURPOSE
//  Producer side of the palette-index interface consumed by the colour mapper. Per pixel, decides
//  whether DrawX/DrawY falls inside one animated sprite box and returns is_sprite plus 5-bit
//  palette index read from a synchronous sprite-sheet ROM. One instance per sprite (player, enemy[i]).
//  Handles 1-cycle ROM latency, walk-animation sequencing and tear-free per-frame latching of position.
// PARAMETERS
//  SPR_W        32   sprite width, pixels
//  SPR_H        32   sprite height, pixels
//  ANIM_FRAMES  4    animation columns per direction row in the sheet
//  ANIM_DIV     6    game frames per animation step
//  ADDR_W       14   ROM address width; must hold 4*SPR_H*ANIM_FRAMES*SPR_W
// PORTS
//  Clk                         in   1       system clock
//  Reset_n                     in   1       asynchronous reset, active-low
//  game_frame_clk_rising_edge  in   1       1-cycle pulse, once per game frame
//  pix_valid                   in   1       DrawX/DrawY valid this cycle
//  DrawX, DrawY                in   10      current pixel coordinate
//  sprite_x, sprite_y          in   10      top-left of sprite box (live, from game logic)
//  sprite_dir                  in   2       facing: selects sheet row 0..3
//  moving                      in   1       1 = animate; 0 = hold column 0
//  visible                     in   1       0 = sprite never drawn
//  mirror                      in   1       horizontal flip request (see CONFIGURATION)
//  rom_addr                    out  ADDR_W  sprite-sheet ROM address
//  rom_data                    in   5       ROM palette index, valid 1 cycle after rom_addr
//  out_valid                   out  1       is_sprite/sprite_index valid
//  is_sprite                   out  1       pixel inside visible sprite box
//  sprite_index                out  5       palette index; 0 = transparent
// BEHAVIOUR
//  - Reset: rom_addr=0, out_valid=0, is_sprite=0, sprite_index=0, anim_col=0, div_cnt=0, shadow regs=0.
//  - Pipeline, fixed latency 2: S0 (pix_valid) compute box test + rom_addr; S1 ROM access;
//    S2 registers out_valid=pix_valid(d2), is_sprite=in_box(d2), sprite_index=in_box(d2)?rom_data:0.
//  - Box test, 11-bit unsigned math, no wrap: in_box = shadow_vis & DrawX>=sx & DrawX<sx+SPR_W
//    & DrawY>=sy & DrawY<sy+SPR_H. Boxes past x=639/y=479 are clipped, never wrapped to column 0.
//  - rx=DrawX-sx, ry=DrawY-sy; addr=((dir*SPR_H+ry)*ANIM_FRAMES+anim_col)*SPR_W+rx.
//    Out-of-box: rom_addr holds previous value; output index forced 0.
//  - Shadow regs {sx,sy,dir,visible,anim_col_used} load only when pix_valid & DrawX==0 & DrawY==0,
//    before that pixel's box test uses them (that pixel sees new values). Mid-frame input changes never tear.
//  - Animation: on game_frame_clk_rising_edge: if !moving -> div_cnt=0, anim_col=0;
//    else if div_cnt==ANIM_DIV-1 -> div_cnt=0, anim_col=(anim_col==ANIM_FRAMES-1)?0:anim_col+1;
//    else div_cnt++. Tick coinciding with frame-origin latch: latch takes pre-tick anim_col.
//  - pix_valid=0: pipeline still shifts; out_valid drops 2 cycles later, outputs otherwise don't-care-held.
//  - Reset_n asserted mid-line: all state clears immediately; first valid output 2 cycles after first pix_valid.
// CONFIGURATION
//  SPRITE_MIRROR_EN defined: when shadowed mirror=1, rx replaced by SPR_W-1-rx (mirror latched with shadow regs).
//  Undefined: mirror port present but ignored; no flip logic synthesised.
// STRUCTURE
//  Shared package sprite_pkg: SPR_W/SPR_H/ANIM_FRAMES defaults, typedef coord_t (logic[9:0]),
//  typedef pal_idx_t (logic[4:0]), typedef enum dir_t {DIR_UP,DIR_DOWN,DIR_LEFT,DIR_RIGHT}.
//  Sub-module sprite_anim_counter: div_cnt/anim_col sequencing only. Box test + address path stay here.
// TESTING
//  1 Reset_n low with pix_valid toggling -> all outputs 0; release, no pixels -> out_valid stays 0.
//  2 sx=100,sy=50,dir=0,anim 0, pixel (100,50) -> rom_addr=0; 2 cycles later is_sprite=1, index=rom_data.
//  3 sx=100: DrawX=131 -> is_sprite=1; DrawX=132 -> is_sprite=0, index=0; DrawX=99 -> 0.
//  4 sx=620,SPR_W=32, DrawX=639 -> in box (rx=19); DrawX=0..11 same line -> never is_sprite.
//  5 moving=1, 24 ticks -> anim_col 0,1,2,3,0 each 6 ticks; moving=0 then 1 tick -> anim_col=0.
//  6 Change sprite_x mid-frame -> remaining pixels use old sx; new sx used from pixel (0,0) onward.
//  7 SPRITE_MIRROR_EN, mirror=1, pixel (100,50) sx=100 -> rom_addr=31; without macro -> rom_addr=0.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sprite geometry defaults, pixel/palette types and facing directions.
package sprite_pkg;

    localparam int unsigned SPR_W_DEF       = 32;
    localparam int unsigned SPR_H_DEF       = 32;
    localparam int unsigned ANIM_FRAMES_DEF = 4;
    localparam int unsigned ANIM_DIV_DEF    = 6;
    localparam int unsigned ADDR_W_DEF      = 14;

    typedef logic [9:0] coord_t;
    typedef logic [4:0] pal_idx_t;

    // Row order in the sprite sheet
    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_anim_counter.sv
// sprite_anim_counter: walk-cycle sequencing. Divides the game-frame tick by ANIM_DIV and
// steps the animation column 0..ANIM_FRAMES-1; a tick while not moving parks it on column 0.
module sprite_anim_counter
    import sprite_pkg::*;
#(
    parameter int unsigned ANIM_FRAMES = ANIM_FRAMES_DEF,
    parameter int unsigned ANIM_DIV    = ANIM_DIV_DEF,
    parameter int unsigned COL_W       = cnt_width(ANIM_FRAMES)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             tick_i,
    input  logic             moving_i,
    output logic [COL_W-1:0] anim_col_o
);

    localparam int unsigned DIV_W = cnt_width(ANIM_DIV);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [COL_W-1:0] anim_col_q, anim_col_d;

    // Next divider/column value; state only moves on a game-frame tick
    always_comb begin
        div_cnt_d  = div_cnt_q;
        anim_col_d = anim_col_q;
        if (tick_i) begin
            if (!moving_i) begin
                div_cnt_d  = '0;
                anim_col_d = '0;
            end else if (div_cnt_q == DIV_W'(ANIM_DIV - 1)) begin
                div_cnt_d  = '0;
                anim_col_d = (anim_col_q == COL_W'(ANIM_FRAMES - 1)) ? '0
                                                                     : anim_col_q + COL_W'(1);
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end
    end

    // Divider and column registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt_q  <= '0;
            anim_col_q <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            anim_col_q <= anim_col_d;
        end
    end

    assign anim_col_o = anim_col_q;

endmodule

// File: rtl/sprite_pixel_fetcher.sv
// sprite_pixel_fetcher: per-pixel box test against one animated sprite and sprite-sheet ROM
// address generation, with a fixed 2-cycle pixel-to-output latency around a 1-cycle ROM.
// Position/facing/visibility/animation column are shadowed at frame origin so a frame never tears.
// Optional feature: define SPRITE_MIRROR_EN to honour the mirror input (horizontal flip).
module sprite_pixel_fetcher
    import sprite_pkg::*;
#(
    parameter int unsigned SPR_W       = SPR_W_DEF,
    parameter int unsigned SPR_H       = SPR_H_DEF,
    parameter int unsigned ANIM_FRAMES = ANIM_FRAMES_DEF,
    parameter int unsigned ANIM_DIV    = ANIM_DIV_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              game_frame_clk_rising_edge,
    input  logic              pix_valid,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic [1:0]        sprite_dir,
    input  logic              moving,
    input  logic              visible,
    input  logic              mirror,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [4:0]        rom_data,
    output logic              out_valid,
    output logic              is_sprite,
    output logic [4:0]        sprite_index
);

    localparam int unsigned COL_W = cnt_width(ANIM_FRAMES);

    // ------------------------------------------------------------------
    // Animation sequencing
    // ------------------------------------------------------------------
    logic [COL_W-1:0] anim_col;

    sprite_anim_counter #(
        .ANIM_FRAMES (ANIM_FRAMES),
        .ANIM_DIV    (ANIM_DIV),
        .COL_W       (COL_W)
    ) u_anim (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .tick_i     (game_frame_clk_rising_edge),
        .moving_i   (moving),
        .anim_col_o (anim_col)
    );

    // ------------------------------------------------------------------
    // Frame-origin shadow registers
    // ------------------------------------------------------------------
    logic             frame_origin;
    coord_t           sx_q, sy_q;
    dir_t             dir_q;
    logic             vis_q;
    logic [COL_W-1:0] col_q;

    coord_t           sx_eff, sy_eff;
    dir_t             dir_eff;
    logic             vis_eff;
    logic [COL_W-1:0] col_eff;

    assign frame_origin = pix_valid && (DrawX == '0) && (DrawY == '0);

    // Shadow load at pixel (0,0); anim_col is the pre-tick value even if a tick lands here
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sx_q  <= '0;
            sy_q  <= '0;
            dir_q <= DIR_UP;
            vis_q <= 1'b0;
            col_q <= '0;
        end else if (frame_origin) begin
            sx_q  <= sprite_x;
            sy_q  <= sprite_y;
            dir_q <= dir_t'(sprite_dir);
            vis_q <= visible;
            col_q <= anim_col;
        end
    end

    // The origin pixel itself must already see the freshly latched values
    always_comb begin
        if (frame_origin) begin
            sx_eff  = sprite_x;
            sy_eff  = sprite_y;
            dir_eff = dir_t'(sprite_dir);
            vis_eff = visible;
            col_eff = anim_col;
        end else begin
            sx_eff  = sx_q;
            sy_eff  = sy_q;
            dir_eff = dir_q;
            vis_eff = vis_q;
            col_eff = col_q;
        end
    end

`ifdef SPRITE_MIRROR_EN
    logic mir_q;
    logic mir_eff;

    // Mirror request is shadowed together with position so a flip never starts mid-frame
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mir_q <= 1'b0;
        end else if (frame_origin) begin
            mir_q <= mirror;
        end
    end

    assign mir_eff = frame_origin ? mirror : mir_q;
`else
    logic unused_mirror;
    assign unused_mirror = mirror;
`endif

    // ------------------------------------------------------------------
    // S0: box test and sheet address
    // ------------------------------------------------------------------
    logic [10:0]       px, py, bx, by;
    logic [10:0]       rx, ry, rx_eff;
    logic              in_box;
    logic              hit;
    logic [ADDR_W-1:0] addr_calc;
    logic [ADDR_W-1:0] addr_q;

    // 11-bit compare so a box hanging past the right/bottom edge clips instead of wrapping
    always_comb begin
        px     = {1'b0, DrawX};
        py     = {1'b0, DrawY};
        bx     = {1'b0, sx_eff};
        by     = {1'b0, sy_eff};
        in_box = vis_eff
                 && (px >= bx) && (px < bx + 11'(SPR_W))
                 && (py >= by) && (py < by + 11'(SPR_H));
        rx     = px - bx;
        ry     = py - by;
`ifdef SPRITE_MIRROR_EN
        rx_eff = mir_eff ? (11'(SPR_W - 1) - rx) : rx;
`else
        rx_eff = rx;
`endif
        addr_calc = ADDR_W'(((32'(dir_eff) * SPR_H + 32'(ry)) * ANIM_FRAMES + 32'(col_eff))
                            * SPR_W + 32'(rx_eff));
    end

    // Reset_n gating keeps rom_addr at 0 while reset is held even if pixels keep arriving
    assign hit      = Reset_n && pix_valid && in_box;
    assign rom_addr = hit ? addr_calc : addr_q;

    // Remember the last issued address so out-of-box pixels leave the ROM address unchanged
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= rom_addr;
        end
    end

    // ------------------------------------------------------------------
    // S1/S2: align valid/hit with the ROM read data
    // ------------------------------------------------------------------
    logic     v1_q, b1_q;
    logic     out_valid_q, is_sprite_q;
    pal_idx_t index_q;

    // Two-stage pipeline; the second stage samples rom_data one cycle after its address
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            v1_q        <= 1'b0;
            b1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            is_sprite_q <= 1'b0;
            index_q     <= '0;
        end else begin
            v1_q        <= pix_valid;
            b1_q        <= hit;
            out_valid_q <= v1_q;
            is_sprite_q <= b1_q;
            index_q     <= b1_q ? rom_data : '0;
        end
    end

    assign out_valid    = out_valid_q;
    assign is_sprite    = is_sprite_q;
    assign sprite_index = index_q;

endmodule

// File: tb/tb_sprite_pixel_fetcher.sv
// tb_sprite_pixel_fetcher: directed scenarios plus randomized pixel streams, checked against a
// frame-level reference model (shadowed sprite state, tick counting, box geometry, sheet layout).
module tb_sprite_pixel_fetcher;

    localparam int SPR_W       = 32;
    localparam int SPR_H       = 32;
    localparam int ANIM_FRAMES = 4;
    localparam int ANIM_DIV    = 6;
`ifdef SPRITE_MIRROR_EN
    localparam bit MIRROR_ON = 1'b1;
`else
    localparam bit MIRROR_ON = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        game_frame_clk_rising_edge;
    logic        pix_valid;
    logic [9:0]  DrawX, DrawY, sprite_x, sprite_y;
    logic [1:0]  sprite_dir;
    logic        moving, visible, mirror;
    logic [13:0] rom_addr;
    logic [4:0]  rom_data;
    logic        out_valid, is_sprite;
    logic [4:0]  sprite_index;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_sx, m_sy, m_dir, m_col, m_ticks, m_addr;
    bit m_vis, m_mir;
    bit prv_v, prv_b, exp_v, exp_b;
    int prv_idx, exp_idx;
    logic [13:0] obs_addr;

    sprite_pixel_fetcher dut (
        .Clk                        (Clk),
        .Reset_n                    (Reset_n),
        .game_frame_clk_rising_edge (game_frame_clk_rising_edge),
        .pix_valid                  (pix_valid),
        .DrawX                      (DrawX),
        .DrawY                      (DrawY),
        .sprite_x                   (sprite_x),
        .sprite_y                   (sprite_y),
        .sprite_dir                 (sprite_dir),
        .moving                     (moving),
        .visible                    (visible),
        .mirror                     (mirror),
        .rom_addr                   (rom_addr),
        .rom_data                   (rom_data),
        .out_valid                  (out_valid),
        .is_sprite                  (is_sprite),
        .sprite_index               (sprite_index)
    );

    always #5 Clk = ~Clk;

    // Sprite-sheet contents: an address hash so a wrong address gives a wrong index
    function automatic logic [4:0] rom_fn(input int a);
        return 5'((a ^ (a >> 5) ^ (a >> 9)) & 31);
    endfunction

    // Synchronous ROM: data valid one cycle after the address
    always @(posedge Clk) rom_data <= rom_fn(int'(rom_addr));

    function automatic bit model_in_box(input int x, input int y);
        return m_vis && x >= m_sx && x < m_sx + SPR_W && y >= m_sy && y < m_sy + SPR_H;
    endfunction

    function automatic int model_addr(input int x, input int y);
        int rx;
        rx = x - m_sx;
        if (MIRROR_ON && m_mir) rx = SPR_W - 1 - rx;
        return ((((m_dir * SPR_H) + (y - m_sy)) * ANIM_FRAMES + m_col) * SPR_W + rx) & 16383;
    endfunction

    task automatic model_clear();
        m_sx = 0; m_sy = 0; m_dir = 0; m_col = 0; m_ticks = 0; m_addr = 0;
        m_vis = 0; m_mir = 0;
        prv_v = 0; prv_b = 0; prv_idx = 0;
        exp_v = 0; exp_b = 0; exp_idx = 0;
    endtask

    // One pixel clock: drive, sample rom_addr, advance model, leave outputs of previous pixel
    task automatic cycle(input bit v, input int x, input int y, input bit tk);
        bit hit;
        int idx;
        pix_valid = v;
        DrawX = 10'(x);
        DrawY = 10'(y);
        game_frame_clk_rising_edge = tk;
        if (v && x == 0 && y == 0) begin
            m_sx  = int'(sprite_x);
            m_sy  = int'(sprite_y);
            m_dir = int'(sprite_dir);
            m_vis = visible;
            m_mir = mirror;
            m_col = (m_ticks / ANIM_DIV) % ANIM_FRAMES;
        end
        hit = v && model_in_box(x, y);
        if (hit) m_addr = model_addr(x, y);
        idx = hit ? int'(rom_fn(m_addr)) : 0;
        #1;
        obs_addr = rom_addr;
        @(posedge Clk);
        if (tk) m_ticks = moving ? m_ticks + 1 : 0;
        exp_v = prv_v; exp_b = prv_b; exp_idx = prv_idx;
        prv_v = v; prv_b = hit; prv_idx = idx;
        #1;
        game_frame_clk_rising_edge = 1'b0;
    endtask

    task automatic set_sprite(input int x, input int y, input int d, input bit vis, input bit mir);
        sprite_x = 10'(x); sprite_y = 10'(y); sprite_dir = 2'(d); visible = vis; mirror = mir;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        model_clear();
        set_sprite(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            pix_valid = (i % 2 == 1);
            DrawX = (i < 4) ? 10'd0 : 10'($urandom_range(0, 639));
            DrawY = (i < 4) ? 10'd0 : 10'($urandom_range(0, 479));
            @(posedge Clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || is_sprite !== 1'b0 || sprite_index !== 5'd0
                || rom_addr !== 14'd0) begin
                errors++;
                $display("FAIL reset_hold: got v=%b s=%b idx=%0d addr=%0d required all 0",
                         out_valid, is_sprite, sprite_index, rom_addr);
            end
        end
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(0, $urandom_range(0, 639), $urandom_range(0, 479), 0);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: out_valid got %b required 0", out_valid);
            end
        end
    endtask

    task automatic test_basic();
        moving = 0;
        set_sprite(100, 50, 0, 1, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 100, 50, 0);
        checks++;
        if (obs_addr !== 14'd0) begin
            errors++;
            $display("FAIL basic_addr: got %0d required 0", obs_addr);
        end
        cycle(0, 0, 0, 0);
        checks++;
        if (out_valid !== 1'b1 || is_sprite !== 1'b1 || sprite_index !== rom_fn(0)) begin
            errors++;
            $display("FAIL basic_out: got v=%b s=%b idx=%0d required v=1 s=1 idx=%0d",
                     out_valid, is_sprite, sprite_index, rom_fn(0));
        end
    endtask

    task automatic test_edges();
        int xs[3]  = '{131, 132, 99};
        bit ins[3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            if (i < 3) cycle(1, xs[i], 60, 0);
            else       cycle(0, 0, 0, 0);
            if (i == 0) begin
                checks++;
                if (obs_addr !== 14'd1311) begin
                    errors++;
                    $display("FAIL edge_addr: got %0d required 1311", obs_addr);
                end
            end else begin
                checks++;
                if (is_sprite !== ins[i-1] || sprite_index !== 5'(exp_idx)) begin
                    errors++;
                    $display("FAIL edge_x%0d: got s=%b idx=%0d required s=%b idx=%0d",
                             xs[i-1], is_sprite, sprite_index, ins[i-1], exp_idx);
                end
            end
        end
    endtask

    task automatic test_clip();
        set_sprite(620, 50, 0, 1, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 639, 60, 0);
        checks++;
        if (obs_addr !== 14'd1299) begin
            errors++;
            $display("FAIL clip_addr: got %0d required 1299", obs_addr);
        end
        for (int j = 0; j <= 12; j++) begin
            if (j < 12) cycle(1, j, 60, 0);
            else        cycle(0, 0, 0, 0);
            checks++;
            if (is_sprite !== (j == 0) || (j < 12 && obs_addr !== 14'd1299)) begin
                errors++;
                $display("FAIL clip_x%0d: got s=%b addr=%0d required s=%b addr=1299",
                         j, is_sprite, obs_addr, (j == 0));
            end
        end
    endtask

    task automatic test_anim();
        int want;
        set_sprite(0, 0, 0, 1, 0);
        moving = 0;
        cycle(0, 5, 5, 1);
        moving = 1;
        for (int k = 1; k <= 24; k++) begin
            cycle(0, 5, 5, 1);
            cycle(1, 0, 0, 0);
            want = ((k / ANIM_DIV) % ANIM_FRAMES) * SPR_W;
            checks++;
            if (obs_addr !== 14'(want)) begin
                errors++;
                $display("FAIL anim_tick%0d: addr got %0d required %0d", k, obs_addr, want);
            end
        end
        cycle(0, 5, 5, 1);
        cycle(0, 5, 5, 1);
        moving = 0;
        cycle(0, 5, 5, 1);
        cycle(1, 0, 0, 0);
        checks++;
        if (obs_addr !== 14'd0) begin
            errors++;
            $display("FAIL anim_stop: addr got %0d required 0", obs_addr);
        end
        moving = 1;
        for (int k = 0; k < ANIM_DIV - 1; k++) cycle(0, 5, 5, 1);
        cycle(1, 0, 0, 1);
        checks++;
        if (obs_addr !== 14'd0) begin
            errors++;
            $display("FAIL anim_coincide: addr got %0d required 0", obs_addr);
        end
        cycle(1, 0, 0, 0);
        checks++;
        if (obs_addr !== 14'd32) begin
            errors++;
            $display("FAIL anim_after: addr got %0d required 32", obs_addr);
        end
        moving = 0;
        cycle(0, 5, 5, 1);
    endtask

    task automatic test_tear();
        set_sprite(100, 50, 0, 1, 0);
        cycle(1, 0, 0, 0);
        set_sprite(200, 50, 2, 1, 0);
        cycle(1, 101, 50, 0);
        checks++;
        if (obs_addr !== 14'd1) begin
            errors++;
            $display("FAIL tear_old_in: addr got %0d required 1", obs_addr);
        end
        cycle(1, 200, 50, 0);
        checks++;
        if (obs_addr !== 14'd1) begin
            errors++;
            $display("FAIL tear_old_out: addr got %0d required 1", obs_addr);
        end
        cycle(1, 0, 0, 0);
        checks++;
        if (is_sprite !== 1'b0) begin
            errors++;
            $display("FAIL tear_old_out_s: is_sprite got %b required 0", is_sprite);
        end
        cycle(1, 200, 50, 0);
        checks++;
        if (obs_addr !== 14'd8192) begin
            errors++;
            $display("FAIL tear_new_in: addr got %0d required 8192", obs_addr);
        end
        cycle(1, 101, 50, 0);
        cycle(0, 0, 0, 0);
        checks++;
        if (is_sprite !== 1'b0 || obs_addr !== 14'd8192) begin
            errors++;
            $display("FAIL tear_new_out: got s=%b addr=%0d required s=0 addr=8192",
                     is_sprite, obs_addr);
        end
    endtask

    task automatic test_mirror();
        set_sprite(100, 50, 0, 1, 1);
        cycle(1, 0, 0, 0);
        cycle(1, 100, 50, 0);
        checks++;
        if (obs_addr !== (MIRROR_ON ? 14'd31 : 14'd0)) begin
            errors++;
            $display("FAIL mirror_addr: got %0d required %0d", obs_addr, MIRROR_ON ? 31 : 0);
        end
        mirror = 1'b0;
        cycle(1, 101, 50, 0);
        checks++;
        if (obs_addr !== (MIRROR_ON ? 14'd30 : 14'd1)) begin
            errors++;
            $display("FAIL mirror_held: got %0d required %0d", obs_addr, MIRROR_ON ? 30 : 1);
        end
    endtask

    task automatic test_reset_midline();
        set_sprite(100, 50, 0, 1, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 110, 55, 0);
        pix_valid = 1'b1;
        #2;
        Reset_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if (out_valid !== 1'b0 || is_sprite !== 1'b0 || sprite_index !== 5'd0
            || rom_addr !== 14'd0) begin
            errors++;
            $display("FAIL midreset_clear: got v=%b s=%b idx=%0d addr=%0d required all 0",
                     out_valid, is_sprite, sprite_index, rom_addr);
        end
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        cycle(0, 5, 5, 0);
        cycle(1, 120, 60, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_lat1: out_valid got %b required 0", out_valid);
        end
        cycle(0, 5, 5, 0);
        checks++;
        if (out_valid !== 1'b1 || is_sprite !== 1'b0) begin
            errors++;
            $display("FAIL midreset_lat2: got v=%b s=%b required v=1 s=0", out_valid, is_sprite);
        end
    endtask

    task automatic test_random();
        int x, y, r;
        bit v, tk;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0)
                set_sprite($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 3),
                           ($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 63) == 0) moving = ~moving;
            v  = ($urandom_range(0, 3) != 0);
            tk = ($urandom_range(0, 7) == 0);
            r  = $urandom_range(0, 15);
            if (r == 0) begin
                x = 0; y = 0;
            end else if (r < 11) begin
                x = m_sx + $urandom_range(0, SPR_W + 8) - 4;
                y = m_sy + $urandom_range(0, SPR_H + 8) - 4;
                if (x < 0) x = 0;
                if (y < 0) y = 0;
            end else begin
                x = $urandom_range(0, 799);
                y = $urandom_range(0, 524);
            end
            cycle(v, x, y, tk);
            checks++;
            if (obs_addr !== 14'(m_addr)) begin
                errors++;
                $display("FAIL rand_addr n=%0d: got %0d required %0d", n, obs_addr, m_addr);
            end
            checks++;
            if (out_valid !== exp_v) begin
                errors++;
                $display("FAIL rand_valid n=%0d: got %b required %b", n, out_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (is_sprite !== exp_b || sprite_index !== 5'(exp_idx)) begin
                    errors++;
                    $display("FAIL rand_pix n=%0d: got s=%b idx=%0d required s=%b idx=%0d",
                             n, is_sprite, sprite_index, exp_b, exp_idx);
                end
            end
        end
    endtask

    initial begin
        pix_valid = 0; DrawX = 0; DrawY = 0; moving = 0;
        game_frame_clk_rising_edge = 0;
        test_reset();
        test_basic();
        test_edges();
        test_clip();
        test_anim();
        test_tear();
        test_mirror();
        test_reset_midline();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
